fb_read_arbiter: RTL and testbench
==================================

Name: fb_read_arbiter

Overview:
- Shares the single read port of the frame-buffer BRAM (18-bit address, 12-bit RGB444 word) between two requesters.
- The display scan-out requester has absolute priority and is never stalled.
- A processing requester (upscaler/filter engine) uses a valid/ready handshake and gets the port on the remaining cycles, typically blanking.
- The block tracks in-flight reads, routes returned data to the correct requester, and reports processing starvation and grant statistics.

Parameters:
ADDR_W, 18, BRAM read address width
DATA_W, 12, BRAM data width
RD_LATENCY, 1, BRAM read latency in cycles from registered address/enable to i_bram_data valid; legal 1..3
STARVE_LIMIT, 64, consecutive refused processing cycles that flag starvation; legal 2..1023

Ports:
i_clk  in  1  pixel clock; the only clock
i_rstn  in  1  reset, synchronous, active-low
i_disp_req  in  1  display read request this cycle
i_disp_addr  in  ADDR_W  display read address
o_disp_valid  out  1  display read data valid
o_disp_data  out  DATA_W  display read data
i_proc_valid  in  1  processing read request
i_proc_addr  in  ADDR_W  processing read address; held stable while i_proc_valid=1 and not accepted
o_proc_ready  out  1  processing request accepted this cycle
o_proc_rvalid  out  1  processing read data valid
o_proc_data  out  DATA_W  processing read data
o_bram_en  out  1  BRAM port-B enable
o_bram_addr  out  ADDR_W  BRAM port-B address
i_bram_data  in  DATA_W  BRAM port-B read data
i_stat_clr  in  1  clears o_proc_starved and o_proc_grants
o_proc_starved  out  1  sticky starvation flag
o_proc_grants  out  16  count of accepted processing requests, wraps

Behaviour:
- Reset (i_rstn=0 at a rising edge of i_clk):
  - Registered outputs clear to 0: o_disp_valid, o_disp_data, o_proc_rvalid, o_proc_data, o_bram_en, o_bram_addr, o_proc_starved, o_proc_grants.
  - Tag pipeline and wait counter clear to 0.
  - In-flight reads are discarded; no valid pulse for them appears after reset.
- Arbitration is combinational: o_proc_ready = ~i_disp_req & i_rstn.
  - Processing handshake fires when i_proc_valid & o_proc_ready.
  - o_proc_ready may be high while i_proc_valid=0; nothing is issued in that case.
- Issue stage (registered at edge t+1 for cycle-t inputs):
  - Display request: o_bram_en=1, o_bram_addr=i_disp_addr.
  - Else processing handshake: o_bram_en=1, o_bram_addr=i_proc_addr.
  - Else: o_bram_en=0 and o_bram_addr holds its previous value.
- Tag pipeline: a 2-bit tag {disp, proc}, delay RD_LATENCY+1, travels alongside each issue. At most one tag bit is set per stage.
- Return stage:
  - A request accepted at cycle t produces its valid at cycle t+2+RD_LATENCY (3 cycles for RD_LATENCY=1).
  - i_bram_data is captured into o_disp_data or o_proc_data according to the tag.
  - o_disp_valid and o_proc_rvalid are single-cycle pulses per read. Back-to-back requests give back-to-back valids with no gaps.
  - o_disp_data is forced to 0 on any cycle where o_disp_valid=0, so blanking outputs black.
  - o_proc_data holds its last value between pulses.
- Starvation:
  - The wait counter increments on each cycle with i_proc_valid=1 and o_proc_ready=0, saturating at STARVE_LIMIT.
  - It clears on a handshake or when i_proc_valid=0.
  - o_proc_starved is set (registered) on the cycle the counter reaches STARVE_LIMIT and stays set until i_stat_clr=1.
  - Set and clear in the same cycle: set wins.
- Grants: o_proc_grants increments by 1 per handshake and wraps from 0xFFFF to 0.
  - i_stat_clr forces it to 0.
  - Handshake coincident with i_stat_clr: result is 1.
- Address values are passed through unmodified; no range checking.

Test Plan:
- Reset, RD_LATENCY=1; i_disp_req=1 with addr 0x00010 at cycle 5 → o_bram_en=1, o_bram_addr=0x00010 at cycle 6; o_disp_valid=1 with o_disp_data = BRAM content at cycle 8; o_disp_data=0 at cycles 7 and 9.
- i_disp_req=0, i_proc_valid=1 for 4 consecutive cycles with addrs 0x100..0x103 → o_proc_ready=1 throughout; 4 back-to-back o_proc_rvalid pulses with data in order; o_proc_grants=4.
- i_proc_valid=1 (addr 0x2AAAA) while i_disp_req=1 for 10 cycles, then disp drops → o_proc_ready=0 for those 10 cycles; addr 0x2AAAA issued on the first cycle after; exactly one o_proc_rvalid; o_proc_starved stays 0.
- i_disp_req=1 for 64 cycles with i_proc_valid=1 → o_proc_starved=1 at the cycle after counter hits 64 and stays set after disp drops; i_stat_clr pulse → starved=0, grants=0.
- Interleave disp and proc every other cycle, RD_LATENCY=3 → every valid lands exactly 5 cycles after its request, on the correct requester, with no cross-routing.
- Assert i_rstn=0 for 1 cycle while 2 reads are in flight → no o_disp_valid/o_proc_rvalid afterwards; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/fb_read_arbiter.sv
// Frame-buffer BRAM read-port arbiter: display scan-out has absolute priority,
// the processing engine fills idle cycles via valid/ready and is starvation-monitored.
module fb_read_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 12,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_proc_valid,
  input  logic [ADDR_W-1:0] i_proc_addr,
  output logic              o_proc_ready,
  output logic              o_proc_rvalid,
  output logic [DATA_W-1:0] o_proc_data,
  output logic              o_bram_en,
  output logic [ADDR_W-1:0] o_bram_addr,
  input  logic [DATA_W-1:0] i_bram_data,
  input  logic              i_stat_clr,
  output logic              o_proc_starved,
  output logic [15:0]       o_proc_grants
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic disp;
    logic proc;
  } tag_t;

  logic                   proc_hs;
  logic                   proc_wait;
  tag_t                   tag_in;
  tag_t                   tag_ret;
  tag_t [RD_LATENCY:0]    tag_q;
  logic [CNT_W-1:0]       wait_cnt;
  logic [CNT_W-1:0]       wait_cnt_nxt;

  // Display never waits; processing only sees ready on cycles display leaves free.
  assign o_proc_ready = ~i_disp_req & i_rstn;
  assign proc_hs      = i_proc_valid & o_proc_ready;
  assign proc_wait    = i_proc_valid & ~o_proc_ready;
  assign tag_in       = '{disp: i_disp_req, proc: proc_hs};
  assign tag_ret      = tag_q[RD_LATENCY];

  always_comb begin
    // NOTE: default first so every path assigns wait_cnt_nxt; no latch is inferred.
    wait_cnt_nxt = '0;
    if (proc_wait) begin
      wait_cnt_nxt = (wait_cnt == CNT_W'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  // Issue stage and tag pipeline; the tag reaching the last stage lines up with i_bram_data.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_rstn) begin
      o_bram_en   <= 1'b0;
      o_bram_addr <= '0;
      // NOTE: the tag pipeline is reset (unlike a data RAM) so in-flight reads are dropped.
      tag_q       <= '0;
    end else begin
      o_bram_en <= i_disp_req | proc_hs;
      if (i_disp_req) begin
        o_bram_addr <= i_disp_addr;
      end else if (proc_hs) begin
        o_bram_addr <= i_proc_addr;
      end
      tag_q <= {tag_q[RD_LATENCY-1:0], tag_in};
    end
  end

  // Return stage: display data is black whenever it is not valid.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_disp_valid  <= 1'b0;
      o_disp_data   <= '0;
      o_proc_rvalid <= 1'b0;
      o_proc_data   <= '0;
    end else begin
      o_disp_valid  <= tag_ret.disp;
      o_disp_data   <= tag_ret.disp ? i_bram_data : '0;
      o_proc_rvalid <= tag_ret.proc;
      if (tag_ret.proc) begin
        o_proc_data <= i_bram_data;
      end
    end
  end

  // Statistics: a starvation set in the same cycle as a clear takes precedence.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wait_cnt       <= '0;
      o_proc_starved <= 1'b0;
      o_proc_grants  <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == CNT_W'(STARVE_LIMIT)) begin
        o_proc_starved <= 1'b1;
      end else if (i_stat_clr) begin
        o_proc_starved <= 1'b0;
      end
      if (i_stat_clr) begin
        o_proc_grants <= proc_hs ? 16'd1 : 16'd0;
      end else if (proc_hs) begin
        o_proc_grants <= o_proc_grants + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: one instance at read latency 1 and one at 3,
// both driven by the same stimulus, each with its own BRAM read model.
module tb_fb_read_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        disp_req;
  logic [17:0] disp_addr;
  logic        proc_valid;
  logic [17:0] proc_addr;
  logic        stat_clr;

  logic        d1_disp_valid, d1_proc_ready, d1_proc_rvalid, d1_bram_en, d1_starved;
  logic [11:0] d1_disp_data, d1_proc_data, d1_bram_data;
  logic [17:0] d1_bram_addr;
  logic [15:0] d1_grants;

  logic        d3_disp_valid, d3_proc_ready, d3_proc_rvalid, d3_bram_en, d3_starved;
  logic [11:0] d3_disp_data, d3_proc_data, d3_bram_data;
  logic [17:0] d3_bram_addr;
  logic [15:0] d3_grants;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fb_read_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_valid(d1_disp_valid), .o_disp_data(d1_disp_data),
    .i_proc_valid(proc_valid), .i_proc_addr(proc_addr),
    .o_proc_ready(d1_proc_ready), .o_proc_rvalid(d1_proc_rvalid), .o_proc_data(d1_proc_data),
    .o_bram_en(d1_bram_en), .o_bram_addr(d1_bram_addr), .i_bram_data(d1_bram_data),
    .i_stat_clr(stat_clr), .o_proc_starved(d1_starved), .o_proc_grants(d1_grants)
  );

  fb_read_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_valid(d3_disp_valid), .o_disp_data(d3_disp_data),
    .i_proc_valid(proc_valid), .i_proc_addr(proc_addr),
    .o_proc_ready(d3_proc_ready), .o_proc_rvalid(d3_proc_rvalid), .o_proc_data(d3_proc_data),
    .o_bram_en(d3_bram_en), .o_bram_addr(d3_bram_addr), .i_bram_data(d3_bram_data),
    .i_stat_clr(stat_clr), .o_proc_starved(d3_starved), .o_proc_grants(d3_grants)
  );

  // BRAM content is a fixed function of the address: data = addr[11:0] + 0x321.
  function automatic logic [11:0] mem_f(input logic [17:0] a);
    return a[11:0] + 12'h321;
  endfunction

  logic [11:0] b1_q;
  logic [11:0] b3_s0, b3_s1, b3_s2;

  always @(posedge clk) begin
    if (d1_bram_en) b1_q <= mem_f(d1_bram_addr);
  end
  assign d1_bram_data = b1_q;

  always @(posedge clk) begin
    if (d3_bram_en) b3_s0 <= mem_f(d3_bram_addr);
    b3_s1 <= b3_s0;
    b3_s2 <= b3_s1;
  end
  assign d3_bram_data = b3_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req   = 1'b0;
    disp_addr  = '0;
    proc_valid = 1'b0;
    proc_addr  = '0;
    stat_clr   = 1'b0;
  endtask

  // k = index of the interleaved request whose return is due this cycle (out of 0..7).
  task automatic chk_ret(input string tag, input logic dv, input logic [11:0] dd,
                         input logic pv, input logic [11:0] pd, input int k);
    if (k >= 0 && k < 8) begin
      check({tag, "_dvalid"}, dv, (k % 2) == 0);
      check({tag, "_pvalid"}, pv, (k % 2) == 1);
      if ((k % 2) == 0) check({tag, "_ddata"}, dd, 12'h821 + 12'(k));
      else              check({tag, "_pdata"}, pd, 12'h921 + 12'(k));
    end else begin
      check({tag, "_dvalid_idle"}, dv, 1'b0);
      check({tag, "_pvalid_idle"}, pv, 1'b0);
      check({tag, "_ddata_idle"},  dd, 12'h000);
    end
  endtask

  task automatic chk_zero(input string tag, input logic en, input logic [17:0] addr,
                          input logic dv, input logic [11:0] dd, input logic pv,
                          input logic [11:0] pd, input logic st, input logic [15:0] gr);
    check({tag, "_bram_en"},   en,   1'b0);
    check({tag, "_bram_addr"}, addr, 18'h0);
    check({tag, "_disp_valid"}, dv,  1'b0);
    check({tag, "_disp_data"},  dd,  12'h0);
    check({tag, "_proc_rvalid"}, pv, 1'b0);
    check({tag, "_proc_data"},  pd,  12'h0);
    check({tag, "_starved"},    st,  1'b0);
    check({tag, "_grants"},     gr,  16'h0);
  endtask

  initial begin
    int n_rv;
    logic [11:0] rv_data;

    idle_inputs();
    rstn = 1'b0;
    #1;
    step();
    step();
    chk_zero("rst1", d1_bram_en, d1_bram_addr, d1_disp_valid, d1_disp_data,
             d1_proc_rvalid, d1_proc_data, d1_starved, d1_grants);
    check("rst_ready", d1_proc_ready, 1'b0);
    rstn = 1'b1;
    step();
    step();

    // Single display read at latency 1
    disp_req  = 1'b1;
    disp_addr = 18'h00010;
    step();
    idle_inputs();
    check("t1_en",    d1_bram_en,   1'b1);
    check("t1_addr",  d1_bram_addr, 18'h00010);
    step();
    check("t1_c7_valid", d1_disp_valid, 1'b0);
    check("t1_c7_data",  d1_disp_data,  12'h000);
    step();
    check("t1_c8_valid", d1_disp_valid, 1'b1);
    check("t1_c8_data",  d1_disp_data,  12'h331);
    step();
    check("t1_c9_valid", d1_disp_valid, 1'b0);
    check("t1_c9_data",  d1_disp_data,  12'h000);
    check("t1_en_idle",  d1_bram_en,    1'b0);
    check("t1_addr_hold", d1_bram_addr, 18'h00010);

    // Four back-to-back processing reads
    for (int i = 0; i < 8; i++) begin
      check("t2_rvalid", d1_proc_rvalid, (i >= 3 && i <= 6));
      if (i >= 3 && i <= 6) check("t2_data", d1_proc_data, 12'h421 + 12'(i - 3));
      proc_valid = (i < 4);
      proc_addr  = 18'h100 + 18'(i);
      #1;
      if (i < 4) check("t2_ready", d1_proc_ready, 1'b1);
      step();
    end
    idle_inputs();
    check("t2_grants", d1_grants, 16'd4);
    check("t2_pdata_hold", d1_proc_data, 12'h424);

    // Processing blocked by 10 display cycles
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        check("t3_disp_valid", d1_disp_valid, 1'b1);
        check("t3_disp_data",  d1_disp_data,  12'h321);
      end
      disp_req   = 1'b1;
      disp_addr  = 18'h03000 + 18'(i);
      proc_valid = 1'b1;
      proc_addr  = 18'h2AAAA;
      #1;
      check("t3_ready_blocked", d1_proc_ready, 1'b0);
      step();
    end
    disp_req = 1'b0;
    #1;
    check("t3_ready_free", d1_proc_ready, 1'b1);
    step();
    idle_inputs();
    check("t3_en",   d1_bram_en,   1'b1);
    check("t3_addr", d1_bram_addr, 18'h2AAAA);
    n_rv    = 0;
    rv_data = '0;
    for (int j = 0; j < 8; j++) begin
      if (d1_proc_rvalid) begin
        n_rv++;
        rv_data = d1_proc_data;
      end
      step();
    end
    check("t3_rvalid_count", 32'(n_rv), 32'd1);
    check("t3_rdata",   rv_data,    12'hDCB);
    check("t3_starved", d1_starved, 1'b0);
    check("t3_grants",  d1_grants,  16'd5);

    // Starvation after 64 refused cycles
    for (int i = 0; i < 64; i++) begin
      disp_req   = 1'b1;
      disp_addr  = 18'h04000;
      proc_valid = 1'b1;
      proc_addr  = 18'h01234;
      step();
      if (i == 62) check("t4_starved_63", d1_starved, 1'b0);
      if (i == 63) check("t4_starved_64", d1_starved, 1'b1);
    end
    idle_inputs();
    step();
    step();
    step();
    check("t4_starved_sticky", d1_starved, 1'b1);
    check("t4_grants_before", d1_grants, 16'd5);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("t4_clr_starved", d1_starved, 1'b0);
    check("t4_clr_grants",  d1_grants,  16'd0);

    // Handshake coincident with clear
    proc_valid = 1'b1;
    proc_addr  = 18'h00055;
    stat_clr   = 1'b1;
    step();
    idle_inputs();
    check("t4_clr_hs_grants", d1_grants, 16'd1);

    // Starvation set coincident with clear: set wins
    for (int i = 0; i < 64; i++) begin
      disp_req   = 1'b1;
      disp_addr  = 18'h04000;
      proc_valid = 1'b1;
      stat_clr   = (i == 63);
      step();
    end
    idle_inputs();
    check("t4_setwins_starved", d1_starved, 1'b1);
    check("t4_setwins_grants",  d1_grants,  16'd0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("t4_final_clr", d1_starved, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // Interleaved display/processing, checked at latency 1 and 3
    for (int i = 0; i < 14; i++) begin
      chk_ret("t5_l1", d1_disp_valid, d1_disp_data, d1_proc_rvalid, d1_proc_data, i - 3);
      chk_ret("t5_l3", d3_disp_valid, d3_disp_data, d3_proc_rvalid, d3_proc_data, i - 5);
      if (i < 8) begin
        disp_req   = (i % 2) == 0;
        disp_addr  = 18'h00500 + 18'(i);
        proc_valid = (i % 2) == 1;
        proc_addr  = 18'h00600 + 18'(i);
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 8 && (i % 2) == 1) check("t5_ready", d1_proc_ready, 1'b1);
      step();
    end
    idle_inputs();
    check("t5_grants_l1", d1_grants, 16'd4);
    check("t5_grants_l3", d3_grants, 16'd4);

    // Reset with two reads in flight
    disp_req  = 1'b1;
    disp_addr = 18'h00010;
    step();
    disp_req   = 1'b0;
    proc_valid = 1'b1;
    proc_addr  = 18'h00020;
    step();
    proc_valid = 1'b0;
    rstn       = 1'b0;
    #1;
    check("t6_ready_in_reset", d1_proc_ready, 1'b0);
    step();
    rstn = 1'b1;
    chk_zero("t6_l1", d1_bram_en, d1_bram_addr, d1_disp_valid, d1_disp_data,
             d1_proc_rvalid, d1_proc_data, d1_starved, d1_grants);
    chk_zero("t6_l3", d3_bram_en, d3_bram_addr, d3_disp_valid, d3_disp_data,
             d3_proc_rvalid, d3_proc_data, d3_starved, d3_grants);
    n_rv = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (d1_disp_valid || d1_proc_rvalid || d3_disp_valid || d3_proc_rvalid) n_rv++;
    end
    check("t6_no_valid_after_reset", 32'(n_rv), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
